ahb_cmd_master: RTL and testbench

AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

---
 rtl/ahb_cmd_master.sv | 151 +++++++++++++++
 tb/tb_ahb_cmd_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cmd_master.sv
// Single-command AHB-Lite master: one non-pipelined transfer per accepted
// command, with alignment screening and a wait-state timeout.
module ahb_cmd_master #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        pll_core_cpuclk,
  input  logic        pad_cpu_rst,
  // Command/response channels: a beat transfers on the cycle valid and ready
  // are both high; a raised valid and its payload hold until that beat.
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic        rsp_err,
  output logic        rsp_tout,
  output logic [31:0] rsp_rdata,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic        hmastlock,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [1:0]  hresp,
  input  logic [31:0] hrdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] tout_cnt_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        rsp_err_q;
  logic        rsp_tout_q;
  logic [31:0] rsp_rdata_q;
  logic        cmd_hs;
  logic        cmd_legal;
  logic        wait_cyc;
  logic        tout_hit;

  assign cmd_hs   = cmd_vld && (state_q == S_IDLE);
  assign wait_cyc = ((state_q == S_ADDR) || (state_q == S_DATA)) && !hready;
  // The counter spans both phases, so the limit bounds the whole transfer.
  assign tout_hit = wait_cyc && (tout_cnt_q == TOUT_LAST);

  always_comb begin
    cmd_legal = 1'b0;
    case (cmd_size)
      2'd0:    cmd_legal = 1'b1;
      2'd1:    cmd_legal = ~cmd_addr[0];
      2'd2:    cmd_legal = (cmd_addr[1:0] == 2'b00);
      default: cmd_legal = 1'b0;
    endcase
  end

  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_hs) state_d = cmd_legal ? S_ADDR : S_RESP;
      S_ADDR: begin
        if (hready)        state_d = S_DATA;
        else if (tout_hit) state_d = S_RESP;
      end
      S_DATA: if (hready || tout_hit) state_d = S_RESP;
      S_RESP: if (rsp_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      tout_cnt_q  <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tout_q  <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (cmd_hs) begin
        write_q    <= cmd_write;
        addr_q     <= cmd_addr;
        wdata_q    <= cmd_wdata;
        size_q     <= cmd_size;
        tout_cnt_q <= '0;
        if (!cmd_legal) begin
          rsp_err_q   <= 1'b1;
          rsp_tout_q  <= 1'b0;
          rsp_rdata_q <= '0;
        end
      end
      if (wait_cyc) tout_cnt_q <= tout_cnt_q + 16'd1;
      if (tout_hit) begin
        rsp_err_q   <= 1'b1;
        rsp_tout_q  <= 1'b1;
        rsp_rdata_q <= '0;
      end else if ((state_q == S_DATA) && hready) begin
        rsp_err_q   <= (hresp == 2'b01);
        rsp_tout_q  <= 1'b0;
        rsp_rdata_q <= (!write_q && (hresp != 2'b01)) ? hrdata : 32'h0;
      end
      // Response fields read as zero whenever no response is offered.
      if ((state_q == S_RESP) && rsp_rdy) begin
        rsp_err_q   <= 1'b0;
        rsp_tout_q  <= 1'b0;
        rsp_rdata_q <= '0;
      end
    end
  end

  always_comb begin
    cmd_rdy   = (state_q == S_IDLE);
    htrans    = (state_q == S_ADDR) ? 2'b10 : 2'b00;
    haddr     = addr_q;
    hwrite    = write_q;
    hsize     = {1'b0, size_q};
    hwdata    = ((state_q == S_DATA) && write_q) ? wdata_q : 32'h0;
    hburst    = 3'b000;
    hprot     = 4'b0011;
    hmastlock = 1'b0;
    rsp_vld   = (state_q == S_RESP);
    rsp_err   = rsp_err_q;
    rsp_tout  = rsp_tout_q;
    rsp_rdata = rsp_rdata_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master: scripted AHB slave, response model
// computed from the command rules, and a per-cycle compare process.
module tb_ahb_cmd_master;

  localparam int TOUT = 16;
  localparam int W    = 34;

  logic        clk = 1'b0;
  logic        pad_cpu_rst;
  logic        cmd_vld, cmd_rdy, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_vld, rsp_rdy, rsp_err, rsp_tout;
  logic [31:0] rsp_rdata;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans, hresp;
  logic        hwrite, hmastlock, hready;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cycle = 0;
  int           nonseq_cnt = 0;
  int           data_cycles = 0;
  logic [1:0]   prev_htrans = 2'b00;
  logic         started = 1'b0;

  ahb_cmd_master #(.TIMEOUT_CYC(TOUT)) dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst(pad_cpu_rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_err(rsp_err),
    .rsp_tout(rsp_tout), .rsp_rdata(rsp_rdata),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata), .dbg_state(dbg_state)
  );

  // Clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Compare process: bus constants, NONSEQ counting, responses vs. model
  always @(negedge clk) begin
    if (started && !pad_cpu_rst) begin
      chk("ahb_const", 64'({hburst, hprot, hmastlock}), 64'({3'b000, 4'b0011, 1'b0}));
      if (htrans == 2'b10 && prev_htrans != 2'b10) nonseq_cnt++;
      prev_htrans = htrans;
      if (exp_q.size() == 0) begin
        chk("rsp_vld_unexpected", 64'(rsp_vld), 64'd0);
      end else if (rsp_vld) begin
        chk("rsp_fields", 64'({rsp_err, rsp_tout, rsp_rdata}), 64'(exp_q[0]));
        chk("rsp_bus_idle_cmd_busy", 64'({htrans, cmd_rdy}), 64'd0);
        if (rsp_rdy) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_haddr"}, 64'(haddr), 64'd0);
    chk({tag, "_hwdata"}, 64'(hwdata), 64'd0);
    chk({tag, "_htrans_hwrite_hsize"}, 64'({htrans, hwrite, hsize}), 64'd0);
    chk({tag, "_cmd_rdy"}, 64'(cmd_rdy), 64'd1);
    chk({tag, "_rsp"}, 64'({rsp_vld, rsp_err, rsp_tout, rsp_rdata}), 64'd0);
  endtask

  // Driver: present a command and wait for its handshake edge.
  task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                           input logic [31:0] wd, output int hs_cyc);
    logic ok;
    cmd_write = wr; cmd_addr = addr; cmd_size = sz; cmd_wdata = wd; cmd_vld = 1'b1;
    ok = 1'b0;
    hs_cyc = cycle;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_rdy) begin ok = 1'b1; break; end
    end
    chk("cmd_rdy_wait", 64'(ok), 64'd1);
    hs_cyc = cycle;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic chk_addr_phase(input logic wr, input logic [31:0] addr, input logic [1:0] sz);
    chk("addr_htrans", 64'(htrans), 64'd2);
    chk("addr_haddr", 64'(haddr), 64'(addr));
    chk("addr_hwrite_hsize", 64'({hwrite, hsize}), 64'({wr, 1'b0, sz}));
  endtask

  task automatic chk_data_phase(input logic wr, input logic [31:0] wd);
    chk("data_htrans", 64'(htrans), 64'd0);
    chk("data_hwdata", 64'(hwdata), wr ? 64'(wd) : 64'd0);
  endtask

  // One full command: model the response, play the slave, take the response.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                         input logic [31:0] wd, input int wa, input int wdw,
                         input logic [1:0] resp, input logic [31:0] rd, input int rdelay,
                         output logic [W-1:0] obs, output int lat);
    logic legal, got;
    logic [W-1:0] exp;
    int waits, ns0, hs_cyc, exp_lat;
    legal = (sz == 2'd0) || (sz == 2'd1 && addr[0] == 1'b0) ||
            (sz == 2'd2 && addr[1:0] == 2'b00);
    if (!legal) begin
      exp = {1'b1, 1'b0, 32'h0};
      exp_lat = 1;
    end else if (wa + wdw >= TOUT) begin
      exp = {1'b1, 1'b1, 32'h0};
      exp_lat = (wa >= TOUT) ? 1 + TOUT : 2 + TOUT;
    end else begin
      exp = {(resp == 2'b01), 1'b0, (!wr && resp != 2'b01) ? rd : 32'h0};
      exp_lat = 3 + wa + wdw;
    end
    exp_q.push_back(exp);
    ns0 = nonseq_cnt;
    data_cycles = 0;
    waits = 0;
    start_cmd(wr, addr, sz, wd, hs_cyc);
    if (legal) begin
      for (int i = 0; i < wa && waits < TOUT; i++) begin
        hready = 1'b0; hresp = 2'b00; hrdata = ~rd;
        @(negedge clk); chk_addr_phase(wr, addr, sz);
        @(posedge clk); #1; waits++;
      end
      if (waits < TOUT) begin
        hready = 1'b1; hresp = 2'b00;
        @(negedge clk); chk_addr_phase(wr, addr, sz);
        @(posedge clk); #1;
        for (int i = 0; i < wdw && waits < TOUT; i++) begin
          hready = 1'b0; hresp = resp; hrdata = ~rd;
          @(negedge clk); chk_data_phase(wr, wd); data_cycles++;
          @(posedge clk); #1; waits++;
        end
        if (waits < TOUT) begin
          hready = 1'b1; hresp = resp; hrdata = rd;
          @(negedge clk); chk_data_phase(wr, wd); data_cycles++;
          @(posedge clk); #1;
        end
      end
      hready = 1'b1; hresp = 2'b00; hrdata = 32'h5A5A_A5A5;
    end
    got = 1'b0;
    obs = '0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_vld) begin got = 1'b1; break; end
    end
    chk("rsp_vld_wait", 64'(got), 64'd1);
    if (got) begin
      obs = {rsp_err, rsp_tout, rsp_rdata};
      lat = cycle - hs_cyc;
      chk("rsp_latency", 64'(lat), 64'(exp_lat));
      @(posedge clk); #1;
      for (int i = 0; i < rdelay; i++) begin @(posedge clk); #1; end
      rsp_rdy = 1'b1;
      @(posedge clk); #1;
      rsp_rdy = 1'b0;
      @(negedge clk);
      chk("cmd_rdy_after_rsp", 64'(cmd_rdy), 64'd1);
      @(posedge clk); #1;
    end
    chk("nonseq_count", 64'(nonseq_cnt - ns0), legal ? 64'd1 : 64'd0);
  endtask

  logic [W-1:0] obs;
  int           lat;
  int           hs_tmp;

  initial begin
    pad_cpu_rst = 1'b1;
    cmd_vld = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    rsp_rdy = 1'b0; hready = 1'b1; hresp = 2'b00; hrdata = '0;
    repeat (3) @(posedge clk);
    #1 pad_cpu_rst = 1'b0;
    started = 1'b1;
    @(negedge clk); check_reset_vals("por");
    @(posedge clk); #1;

    // Zero-wait word read
    run_cmd(1'b0, 32'h1000_0004, 2'd2, 32'h0, 0, 0, 2'b00, 32'hCAFE_F00D, 0, obs, lat);
    chk("t1_rdata", 64'(obs[31:0]), 64'h0000_0000_CAFE_F00D);
    chk("t1_err_tout", 64'(obs[33:32]), 64'd0);
    chk("t1_latency", 64'(lat), 64'd3);

    // Half write with two data wait states
    run_cmd(1'b1, 32'h2000_0002, 2'd1, 32'h0000_1234, 0, 2, 2'b00, 32'hDEAD_BEEF, 2, obs, lat);
    chk("t2_data_cycles", 64'(data_cycles), 64'd3);
    chk("t2_rsp", 64'(obs), 64'd0);

    // ERROR held through a wait cycle, then completing
    run_cmd(1'b0, 32'h3000_0000, 2'd2, 32'h0, 0, 1, 2'b01, 32'h1111_2222, 1, obs, lat);
    chk("t3_rsp", 64'(obs), 64'h2_0000_0000);

    // Timeout while the slave never accepts the address
    run_cmd(1'b0, 32'h0000_0100, 2'd2, 32'h0, 1000, 0, 2'b00, 32'h3333_4444, 0, obs, lat);
    chk("t4_err_tout", 64'(obs[33:32]), 64'd3);
    chk("t4_latency", 64'(lat), 64'd17);

    // Counter spans both phases: 10 + 6 waits times out, 10 + 5 does not
    run_cmd(1'b1, 32'h4000_0003, 2'd0, 32'h0000_00A5, 10, 6, 2'b00, 32'h0, 0, obs, lat);
    run_cmd(1'b0, 32'h5000_0006, 2'd1, 32'h0, 10, 5, 2'b00, 32'h1357_9BDF, 0, obs, lat);
    chk("t6_rdata", 64'(obs), 64'h0_1357_9BDF);

    // Illegal commands never reach the bus
    run_cmd(1'b0, 32'h0000_0006, 2'd2, 32'h0, 0, 0, 2'b00, 32'h0, 0, obs, lat);
    chk("t7_rsp", 64'(obs), 64'h2_0000_0000);
    run_cmd(1'b1, 32'h0000_0000, 2'd3, 32'hFFFF_FFFF, 0, 0, 2'b00, 32'h0, 1, obs, lat);
    run_cmd(1'b0, 32'h0000_0011, 2'd1, 32'h0, 0, 0, 2'b00, 32'h0, 0, obs, lat);

    // Write answered with zero-wait ERROR
    run_cmd(1'b1, 32'h6000_0008, 2'd2, 32'h8765_4321, 0, 0, 2'b01, 32'h9999_9999, 0, obs, lat);

    // Reset while in the data phase with rsp_rdy already high
    start_cmd(1'b0, 32'h7000_0000, 2'd2, 32'h0, hs_tmp);
    hready = 1'b1;
    @(posedge clk); #1;
    hready = 1'b0; rsp_rdy = 1'b1; pad_cpu_rst = 1'b1;
    @(posedge clk); #1;
    pad_cpu_rst = 1'b0; hready = 1'b1;
    @(negedge clk); check_reset_vals("mid_rst");
    repeat (5) @(posedge clk);
    #1 rsp_rdy = 1'b0;
    prev_htrans = 2'b00;

    run_cmd(1'b0, 32'h7000_0010, 2'd2, 32'h0, 1, 1, 2'b00, 32'h0BAD_F00D, 0, obs, lat);
    chk("t_after_rst_rdata", 64'(obs), 64'h0_0BAD_F00D);

    repeat (3) @(posedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
